// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: address decode into EEPROM/RAM/peripheral selects,
// DTACK wait-state or external acknowledge, BERR generation, boot overlay.
module m68k_bus_ctrl #(
  parameter int             NCS         = 4,
  parameter logic [10:0]    CS_BASE     = 11'h700,
  parameter int             CS_PAGES    = 8,
  parameter int             WS_EEPROM   = 4,
  parameter int             WS_RAM      = 1,
  parameter int             WS_CS       = 2,
  parameter logic [NCS-1:0] EXT_DTACK   = '0,
  parameter bit             EEPROM_WP   = 1'b1,
  parameter int             BERR_CYCLES = 255
) (
  input  logic           clk50,
  input  logic           reset,
  input  logic           as_n,
  input  logic           uds_n,
  input  logic           lds_n,
  input  logic           rw,
  input  logic [10:0]    addr,
  input  logic           boot,
  input  logic           dtack_trig,
  output logic           dtack_n,
  output logic           berr_n,
  output logic           oe_n,
  output logic           ram_ce_n,
  output logic           eeprom_uds_n,
  output logic           eeprom_lds_n,
  output logic [NCS-1:0] cs
);

  localparam int              TW       = $clog2(BERR_CYCLES + 1);
  localparam int              PSH      = $clog2(CS_PAGES);
  localparam logic [11:0]     CS_SPAN  = 12'(NCS * CS_PAGES);
  localparam logic [TW-1:0]   TMO_LAST = TW'(BERR_CYCLES - 1);
  localparam logic [TW-1:0]   TMO_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BERR} state_t;
  typedef enum logic [1:0] {RG_NONE, RG_RAM, RG_EEP, RG_CS} region_t;

  logic [1:0] r_as_sy, r_uds_sy, r_lds_sy, r_trig_sy;
  logic       w_as_s, w_uds_s, w_lds_s, w_trig_s;

  state_t        r_st, w_st_nxt;
  region_t       r_rgn, w_rgn_nxt, w_rgn;
  logic [2:0]    r_k, w_k_nxt, w_k;
  logic          r_rw, w_rw_nxt;
  logic          r_err, w_err_nxt, w_err;
  logic [3:0]    r_cnt, w_cnt_nxt, w_ws;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          r_ovl, w_ovl_nxt;

  logic          w_ovl, w_in_cs, w_ext, w_en;
  logic [11:0]   w_off;
  logic          w_dtack_d, w_berr_d, w_oe_d, w_ram_d, w_euds_d, w_elds_d;
  logic [NCS-1:0] w_cs_d;

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_as_sy   <= 2'b11;
      r_uds_sy  <= 2'b11;
      r_lds_sy  <= 2'b11;
      r_trig_sy <= 2'b00;
    end else begin
      r_as_sy   <= {r_as_sy[0], as_n};
      r_uds_sy  <= {r_uds_sy[0], uds_n};
      r_lds_sy  <= {r_lds_sy[0], lds_n};
      r_trig_sy <= {r_trig_sy[0], dtack_trig};
    end
  end

  assign w_as_s   = r_as_sy[1];
  assign w_uds_s  = r_uds_sy[1];
  assign w_lds_s  = r_lds_sy[1];
  assign w_trig_s = r_trig_sy[1];

  // Address decode; boot strap takes effect immediately, before r_ovl catches up.
  assign w_ovl   = r_ovl | boot;
  assign w_off   = {1'b0, addr} - {1'b0, CS_BASE};
  assign w_in_cs = (addr >= CS_BASE) && (w_off < CS_SPAN);
  assign w_k     = w_off[PSH +: 3];

  always_comb begin
    w_rgn = RG_NONE;
    w_ws  = '0;
    if (addr >= 11'h780 || (w_ovl && rw && addr < 11'd8)) begin
      w_rgn = RG_EEP;
      w_ws  = 4'(WS_EEPROM);
    end else if (w_in_cs) begin
      w_rgn = RG_CS;
      w_ws  = 4'(WS_CS);
    end else if (addr < 11'h400) begin
      w_rgn = RG_RAM;
      w_ws  = 4'(WS_RAM);
    end
    w_err = (w_rgn == RG_NONE) || (w_rgn == RG_EEP && !rw && EEPROM_WP);
  end

  always_comb begin
    w_ext = 1'b0;
    for (int i = 0; i < NCS; i++)
      if (r_k == 3'(i)) w_ext = EXT_DTACK[i];
    w_ext = w_ext && (r_rgn == RG_CS);
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_st  <= S_IDLE;
      r_rgn <= RG_NONE;
      r_k   <= '0;
      r_rw  <= 1'b1;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_tmo <= '0;
      r_ovl <= 1'b1;
    end else begin
      r_st  <= w_st_nxt;
      r_rgn <= w_rgn_nxt;
      r_k   <= w_k_nxt;
      r_rw  <= w_rw_nxt;
      r_err <= w_err_nxt;
      r_cnt <= w_cnt_nxt;
      r_tmo <= w_tmo_nxt;
      r_ovl <= w_ovl_nxt;
    end
  end

  // Timeout outranks a same-cycle acknowledge; abort outranks a late acknowledge.
  always_comb begin
    w_st_nxt  = r_st;
    w_rgn_nxt = r_rgn;
    w_k_nxt   = r_k;
    w_rw_nxt  = r_rw;
    w_err_nxt = r_err;
    w_cnt_nxt = r_cnt;
    w_tmo_nxt = r_tmo;
    w_ovl_nxt = r_ovl | boot;
    unique case (r_st)
      S_IDLE: if (!w_as_s && (!w_uds_s || !w_lds_s)) begin
        w_st_nxt  = S_WAIT;
        w_rgn_nxt = w_err ? RG_NONE : w_rgn;
        w_k_nxt   = w_k;
        w_rw_nxt  = rw;
        w_err_nxt = w_err;
        w_cnt_nxt = w_ws;
        w_tmo_nxt = '0;
        if (!rw && !boot) w_ovl_nxt = 1'b0;
      end
      S_WAIT: begin
        if (r_tmo != TMO_MAX) w_tmo_nxt = r_tmo + 1'b1;
        if (r_err || r_tmo == TMO_LAST) w_st_nxt = S_BERR;
        else if (w_as_s)                w_st_nxt = S_IDLE;
        else if (r_cnt != '0)           w_cnt_nxt = r_cnt - 1'b1;
        else if (!w_ext || w_trig_s)    w_st_nxt = S_ACK;
      end
      default: if (w_as_s) w_st_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    w_en      = (w_st_nxt == S_WAIT) || (w_st_nxt == S_ACK);
    w_dtack_d = (w_st_nxt != S_ACK);
    w_berr_d  = (w_st_nxt != S_BERR);
    w_oe_d    = !(w_en && w_rgn_nxt != RG_NONE && w_rw_nxt);
    w_ram_d   = !(w_en && w_rgn_nxt == RG_RAM);
    w_euds_d  = (w_en && w_rgn_nxt == RG_EEP) ? w_uds_s : 1'b1;
    w_elds_d  = (w_en && w_rgn_nxt == RG_EEP) ? w_lds_s : 1'b1;
    for (int i = 0; i < NCS; i++)
      w_cs_d[i] = w_en && (w_rgn_nxt == RG_CS) && (w_k_nxt == 3'(i));
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      dtack_n      <= 1'b1;
      berr_n       <= 1'b1;
      oe_n         <= 1'b1;
      ram_ce_n     <= 1'b1;
      eeprom_uds_n <= 1'b1;
      eeprom_lds_n <= 1'b1;
      cs           <= '0;
    end else begin
      dtack_n      <= w_dtack_d;
      berr_n       <= w_berr_d;
      oe_n         <= w_oe_d;
      ram_ce_n     <= w_ram_d;
      eeprom_uds_n <= w_euds_d;
      eeprom_lds_n <= w_elds_d;
      cs           <= w_cs_d;
    end
  end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: directed scenarios plus random bus cycles, each
// checked edge by edge against a timeline computed from the memory-map rules.
module tb_m68k_bus_ctrl;
  logic        clk50 = 1'b0, reset = 1'b1;
  logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [10:0] addr = '0;
  logic        boot = 1'b0, dtack_trig = 1'b0;
  logic        dtack_n, berr_n, oe_n, ram_ce_n, eeprom_uds_n, eeprom_lds_n;
  logic [3:0]  cs;

  int errs = 0, checks = 0;
  bit model_ovl = 1'b1;
  localparam logic [9:0] IDLE_V = 10'b11_1111_0000;
  localparam int TMO_EDGE = 3 + 255;

  m68k_bus_ctrl #(.EXT_DTACK(4'b0001)) dut (
    .clk50(clk50), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .addr(addr), .boot(boot), .dtack_trig(dtack_trig),
    .dtack_n(dtack_n), .berr_n(berr_n), .oe_n(oe_n), .ram_ce_n(ram_ce_n),
    .eeprom_uds_n(eeprom_uds_n), .eeprom_lds_n(eeprom_lds_n), .cs(cs));

  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {dtack_n, berr_n, oe_n, ram_ce_n, eeprom_uds_n, eeprom_lds_n, cs};
  endfunction

  task automatic idle(input int n, input string nm);
    repeat (n) begin
      @(negedge clk50);
      chk({nm, " idle"}, 32'(outs()), 32'(IDLE_V));
    end
  endtask

  // One bus cycle. Called just after a negedge. t = edge at which dtack_trig is
  // first sampled high (0 = never); abort_at = edge at which as_n is first
  // sampled high if earlier than the natural end of the cycle (0 = none).
  task automatic run_txn(input logic [10:0] p, input logic rwv, input logic un,
                         input logic ln, input int t, input int abort_at, input string nm);
    int rg, k, ws, d, b, r, e, ev;
    bit err, has_d, has_b, ext, ov, en, dl, bl;
    logic [9:0] exp;
    logic [3:0] csx;
    ov = model_ovl || boot;
    k  = 0;
    if (p >= 11'h780 || (ov && rwv && p < 11'd8)) rg = 2;
    else if (p >= 11'h700 && p < 11'h720) begin rg = 3; k = (int'(p) - 'h700) / 8; end
    else if (p < 11'h400) rg = 1;
    else rg = 0;
    err = (rg == 0) || (rg == 2 && !rwv);
    ws  = (rg == 1) ? 1 : (rg == 2) ? 4 : 2;
    ext = (rg == 3) && (k == 0);
    has_d = 1'b0; has_b = 1'b0; d = 0; b = 0;
    if (err) begin
      has_b = 1'b1; b = 4;
    end else begin
      if (!ext)       d = ws + 4;
      else if (t > 0) d = (t + 2 > ws + 4) ? t + 2 : ws + 4;
      else            d = 1000000;
      if (d >= TMO_EDGE) begin has_b = 1'b1; b = TMO_EDGE; end
      else has_d = 1'b1;
    end
    ev = has_b ? b : d;
    r  = ev + 1;
    if (abort_at > 0 && abort_at < r) r = abort_at;
    e  = r + 2;
    if (!boot && !rwv) model_ovl = 1'b0;

    addr = p; rw = rwv; uds_n = un; lds_n = ln; as_n = 1'b0;
    for (int n = 1; n <= e; n++) begin
      @(negedge clk50);
      en  = !err && n >= 3 && n < e && (!has_b || n < b);
      dl  = has_d && n >= d && n < e;
      bl  = has_b && n >= b && n < e;
      csx = (en && rg == 3) ? 4'(1 << k) : 4'b0000;
      exp = {~dl, ~bl, ~(en && rwv), ~(en && rg == 1),
             (en && rg == 2) ? un : 1'b1, (en && rg == 2) ? ln : 1'b1, csx};
      chk($sformatf("%s p=%h n=%0d", nm, p, n), 32'(outs()), 32'(exp));
      if (n + 1 == t && n + 1 < r) dtack_trig = 1'b1;
      if (n + 1 == r) begin
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; dtack_trig = 1'b0;
      end
    end
    idle(2, nm);
  endtask

  function automatic logic [10:0] rnd_page();
    case ($urandom_range(0, 5))
      0:       return 11'($urandom_range(0, 7));
      1:       return 11'($urandom_range(0, 'h3FF));
      2:       return 11'($urandom_range('h780, 'h7FF));
      3:       return 11'($urandom_range('h700, 'h71F));
      4:       return 11'($urandom_range('h400, 'h6FF));
      default: return 11'($urandom_range('h720, 'h77F));
    endcase
  endfunction

  initial begin
    logic [1:0] ul;
    repeat (3) @(negedge clk50);
    chk("reset", 32'(outs()), 32'(IDLE_V));
    reset = 1'b0;
    idle(2, "post_rst");

    run_txn(11'h200, 1'b1, 1'b0, 1'b0, 0, 0, "ram_rd");
    // overlay, boot = 0
    run_txn(11'h000, 1'b1, 1'b0, 1'b0, 0, 0, "ovl_rd");
    run_txn(11'h000, 1'b0, 1'b0, 1'b1, 0, 0, "ovl_wr");
    run_txn(11'h000, 1'b1, 1'b1, 1'b0, 0, 0, "ovl_rd2");
    // overlay, boot = 1
    reset = 1'b1; @(negedge clk50); reset = 1'b0; model_ovl = 1'b1;
    boot = 1'b1; idle(2, "boot");
    run_txn(11'h003, 1'b1, 1'b0, 1'b0, 0, 0, "boot_rd");
    run_txn(11'h003, 1'b0, 1'b0, 1'b0, 0, 0, "boot_wr");
    run_txn(11'h003, 1'b1, 1'b0, 1'b0, 0, 0, "boot_rd2");
    boot = 1'b0;
    run_txn(11'h710, 1'b1, 1'b0, 1'b0, 0, 0, "cs2");
    run_txn(11'h700, 1'b1, 1'b0, 1'b0, 20, 0, "ext_trig");
    run_txn(11'h702, 1'b0, 1'b0, 1'b0, 2, 0, "ext_early");
    run_txn(11'h700, 1'b1, 1'b0, 1'b0, 0, 0, "ext_tmo");
    run_txn(11'h700, 1'b1, 1'b0, 1'b0, TMO_EDGE - 2, 0, "ext_tie");
    run_txn(11'h500, 1'b1, 1'b0, 1'b0, 0, 0, "unmapped");
    run_txn(11'h780, 1'b0, 1'b0, 1'b0, 0, 0, "eep_wp");
    run_txn(11'h790, 1'b1, 1'b0, 1'b0, 0, 4, "abort");

    // reset in the middle of a wait
    addr = 11'h790; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk50);
      chk($sformatf("mid_rst n=%0d", n), 32'(outs()),
          32'((n >= 3) ? 10'b11_0100_0000 : IDLE_V));
    end
    reset = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk50);
    chk("mid_rst out", 32'(outs()), 32'(IDLE_V));
    reset = 1'b0; model_ovl = 1'b1;
    idle(2, "mid_rst");

    for (int i = 0; i < 80; i++) begin
      if (i % 10 == 0) begin
        boot = ($urandom_range(0, 3) == 0);
        idle(1, "boot_chg");
      end
      ul = 2'($urandom_range(0, 2));
      run_txn(rnd_page(), 1'($urandom_range(0, 1)), ul[1], ul[0],
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 20)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 10)) : 0,
              $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
